// File: rtl/pot_dot_accumulator.sv
// Signed dot-product accumulator over variable-length vectors with a one-deep
// valid/ready result holding stage. Define POT_ACC_SAT_EN to saturate the sum.
//
// Handshakes: a beat transfers on a cycle where result_vld && in_rdy; a result
// transfers on a cycle where out_vld && out_rdy. While out_vld is high and
// out_rdy is low, sum/beats/len_err are frozen and in_rdy is held low.
module pot_dot_accumulator #(
    parameter int a_N     = 4,
    parameter int N       = 3,
    parameter int MAX_LEN = 16,
    parameter int ACC_W   = 17,
    parameter int OUT_W   = 12,
    localparam int C_W     = a_N + (1 << N) + 1,
    localparam int BEATS_W = $clog2(MAX_LEN) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [C_W-1:0]     c,
    input  logic                      result_vld,
    input  logic                      last,
    output logic                      in_rdy,
    output logic signed [OUT_W-1:0]   sum,
    output logic [BEATS_W-1:0]        beats,
    output logic                      len_err,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic                      o_dbg_state
);

    localparam int CNT_W = $clog2(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               r_state;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [OUT_W-1:0]     r_sum;
    logic [BEATS_W-1:0]   r_beats;
    logic                 r_len_err;
    logic                 r_out_vld;

    logic                 w_in_rdy;
    logic                 w_accept;
    logic                 w_close;
    logic [ACC_W-1:0]     w_c_ext;
    logic [ACC_W-1:0]     w_acc_next;
    logic [OUT_W-1:0]     w_sum_next;

    // A held result only blocks new beats while downstream is not taking it.
    assign w_in_rdy   = (r_state == ST_ACCUM) || out_rdy;
    assign w_accept   = result_vld && w_in_rdy;
    assign w_close    = w_accept && (last || (r_cnt == CNT_LAST));
    assign w_c_ext    = {{(ACC_W - C_W){c[C_W-1]}}, c};
    assign w_acc_next = r_acc + w_c_ext;

`ifdef POT_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    always_comb begin
        w_sum_next = w_acc_next[OUT_W-1:0];
        if ($signed(w_acc_next) > SAT_MAX) begin
            w_sum_next = SAT_MAX[OUT_W-1:0];
        end else if ($signed(w_acc_next) < SAT_MIN) begin
            w_sum_next = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    assign w_sum_next = w_acc_next[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_beats   <= '0;
            r_len_err <= 1'b0;
            r_out_vld <= 1'b0;
        end else if (w_accept) begin
            if (w_close) begin
                // A forced close at MAX_LEN is the only way to close without last.
                r_sum     <= w_sum_next;
                r_beats   <= BEATS_W'(r_cnt) + BEATS_W'(1);
                r_len_err <= !last;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_state   <= ST_HOLD;
                r_out_vld <= 1'b1;
            end else begin
                r_acc     <= w_acc_next;
                r_cnt     <= r_cnt + CNT_W'(1);
                r_state   <= ST_ACCUM;
                r_out_vld <= 1'b0;
            end
        end else if ((r_state == ST_HOLD) && out_rdy) begin
            r_state   <= ST_ACCUM;
            r_out_vld <= 1'b0;
        end
    end

    assign in_rdy      = w_in_rdy;
    assign sum         = r_sum;
    assign beats       = r_beats;
    assign len_err     = r_len_err;
    assign out_vld     = r_out_vld;
    assign o_dbg_state = (r_state == ST_HOLD);

endmodule

// File: doc/pot_dot_accumulator.md
Name: pot_dot_accumulator

Overview:
- Downstream consumer of the power-of-two-term multiplier stage.
- Takes its signed partial products c (one per valid beat) and accumulates them into a dot-product sum over a variable-length vector delimited by a last flag.
- Presents each finished sum on a valid/ready output with one-deep holding, and applies backpressure upstream while the result is unclaimed.

Parameters:
- a_N, 4, activation width of the upstream multiplier.
- N, 3, shift-code width of the upstream multiplier; C_W = a_N + (1 << N) + 1 (13 at defaults) is the input product width.
- MAX_LEN, 16, maximum beats per vector; a power of 2, at least 2.
- ACC_W, 17, internal accumulator width; must be at least C_W + $clog2(MAX_LEN).
- OUT_W, 12, output sum width; must be no greater than ACC_W.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- c  input  C_W  signed two's-complement partial product from the multiplier.
- result_vld  input  1  c is valid this cycle.
- last  input  1  qualifies result_vld; this beat closes the vector.
- in_rdy  output  1  block accepts a beat this cycle.
- sum  output  OUT_W  signed dot-product result.
- beats  output  $clog2(MAX_LEN)+1  number of beats folded into sum.
- len_err  output  1  vector was force-closed at MAX_LEN without last.
- out_vld  output  1  sum/beats/len_err valid.
- out_rdy  input  1  downstream accepts the result.

Behaviour:
- Reset: asynchronous, active-low. acc=0, cnt=0, state=ACCUM, sum=0, beats=0, len_err=0, out_vld=0. Reset asserted mid-vector discards the partial sum and any held result.
- Beat accepted = result_vld && in_rdy.
- c is sign-extended to ACC_W before adding. The accumulator wraps modulo 2^ACC_W, which is unreachable when the parameters are legal.
- States:
  - ACCUM: in_rdy=1, out_vld=0.
    - Accepted beat without last: acc += c, cnt++.
    - Accepted beat with last: sum = f(acc+c), beats = cnt+1, len_err=0, acc=0, cnt=0, go to HOLD.
    - Accepted non-last beat with cnt==MAX_LEN-1: closes as if last, with len_err=1. The next beat starts a new vector.
  - HOLD: out_vld=1, outputs stable; in_rdy = out_rdy.
    - out_rdy=1 with no beat: go to ACCUM.
    - out_rdy=1 with an accepted beat: process it exactly as in ACCUM on the same cycle. The result is released; if that beat closes a vector, stay in HOLD with the new result.
    - out_rdy=0: hold all outputs; in_rdy=0.
- Latency: out_vld rises the cycle after the closing beat is accepted. Back-to-back one-beat vectors with out_rdy=1 sustain one result per cycle.
- Single-beat vector (last on first beat): sum = f(c), beats = 1.
- result_vld=0: no state change. last is ignored unless result_vld=1.
- sum, beats and len_err are registered.
- f() is the output narrowing defined by the optional feature.

Optional Feature:
- Macro: POT_ACC_SAT_EN.
- Defined: f() saturates ACC_W to OUT_W signed. Values above 2^(OUT_W-1)-1 give 2^(OUT_W-1)-1; values below -2^(OUT_W-1) give -2^(OUT_W-1).
- Undefined: f() keeps the low OUT_W bits (two's-complement wrap).
- No other behaviour differs between the two builds.

Test Plan:
- Reset then four beats c=100,200,-50,25 with last on the 4th and out_rdy=1 -> one cycle later out_vld=1, sum=275, beats=4, len_err=0; out_vld drops the following cycle.
- Four beats of c=1000, last on the 4th -> with POT_ACC_SAT_EN sum=2047; without it sum=-96 (4000 wrapped to 12 bits).
- 16 beats of c=1 with no last -> sum=16, beats=16, len_err=1; the 17th beat c=5 with last -> next result sum=5, beats=1, len_err=0.
- Closing beat sum=7, then out_rdy=0 for 5 cycles while result_vld=1 -> in_rdy=0, outputs frozen, no beats lost. Raise out_rdy -> new beats accepted that same cycle.
- Continuous single-beat vectors c=3,-4,5 each with last, out_rdy=1 -> sums 3,-4,5 on consecutive cycles, out_vld held high, in_rdy never drops.
- Drive rst_n low asynchronously after 2 beats (c=9,9), release, then send c=1 with last -> sum=1, beats=1, and out_vld=0 during reset.
